// File: rtl/fifo_pkg.sv
// Shared constants for the FIFO stream reader and its output buffer.
package fifo_pkg;

    localparam int unsigned DATA_WIDTH_DEFAULT = 16;
    localparam int unsigned PKT_LEN_DEFAULT    = 8;
    localparam int unsigned PKT_CNT_WIDTH      = 16;

    // Output buffer depth; the credit check in the top module relies on this.
    localparam int unsigned SKID_DEPTH = 2;

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry FIFO-ordered output buffer. Entry 0 is always the head.
// The caller guarantees it never pushes into a full buffer.
module stream_skid_buf
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_push_data,
    input  logic                  i_pop,
    output logic [1:0]            o_occ,
    output logic [DATA_WIDTH-1:0] o_head
);

    logic [DATA_WIDTH-1:0] r_ent0;
    logic [DATA_WIDTH-1:0] r_ent1;
    logic [1:0]            r_occ;

    logic [DATA_WIDTH-1:0] w_ent0_d;
    logic [DATA_WIDTH-1:0] w_ent1_d;
    logic [1:0]            w_occ_d;
    logic                  w_pop;

    assign w_pop  = i_pop && (r_occ != 2'd0);
    assign o_occ  = r_occ;
    assign o_head = r_ent0;

    // Next-state: shift on pop, append at the tail on push.
    always_comb begin
        w_ent0_d = r_ent0;
        w_ent1_d = r_ent1;
        w_occ_d  = r_occ;
        case ({i_push, w_pop})
            2'b10: begin
                if (r_occ == 2'd0) begin
                    w_ent0_d = i_push_data;
                    w_occ_d  = 2'd1;
                end else if (r_occ == 2'd1) begin
                    w_ent1_d = i_push_data;
                    w_occ_d  = 2'd2;
                end
            end
            2'b01: begin
                w_ent0_d = r_ent1;
                w_occ_d  = r_occ - 2'd1;
            end
            2'b11: begin
                // Occupancy unchanged; the new word lands behind what remains.
                if (r_occ == 2'd1) begin
                    w_ent0_d = i_push_data;
                end else begin
                    w_ent0_d = r_ent1;
                    w_ent1_d = i_push_data;
                end
            end
            default: ;
        endcase
    end

    // Buffer registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ent0 <= '0;
            r_ent1 <= '0;
            r_occ  <= 2'd0;
        end else begin
            r_ent0 <= w_ent0_d;
            r_ent1 <= w_ent1_d;
            r_occ  <= w_occ_d;
        end
    end

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a 1-cycle-latency sync FIFO into a valid/ready stream, marking
// packet boundaries every PKT_LEN words and counting completed packets.
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int unsigned PKT_LEN    = PKT_LEN_DEFAULT
) (
    input  logic                     i_sys_clk,
    input  logic                     i_sys_rst,
    output logic                     o_fifo_rden,
    input  logic [DATA_WIDTH-1:0]    i_fifo_rdata,
    input  logic                     i_fifo_empty,
    output logic [DATA_WIDTH-1:0]    o_tdata,
    output logic                     o_tvalid,
    input  logic                     i_tready,
    output logic                     o_tlast,
    output logic [PKT_CNT_WIDTH-1:0] o_pkt_cnt
);

    localparam logic [15:0] LAST_IDX = 16'(PKT_LEN - 1);
    localparam logic [2:0]  DEPTH    = 3'(SKID_DEPTH);

    logic                     r_inflight;
    logic [15:0]              r_wcnt;
    logic [PKT_CNT_WIDTH-1:0] r_pkt_cnt;

    logic [1:0]            w_occ;
    logic [DATA_WIDTH-1:0] w_head;
    logic                  w_pop;
    logic [2:0]            w_used;

    stream_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .i_clk       (i_sys_clk),
        .i_rst       (i_sys_rst),
        .i_push      (r_inflight),
        .i_push_data (i_fifo_rdata),
        .i_pop       (w_pop),
        .o_occ       (w_occ),
        .o_head      (w_head)
    );

    // Credit check: buffered + in-flight words, less the word leaving now.
    always_comb begin
        w_pop       = o_tvalid && i_tready;
        w_used      = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
        o_fifo_rden = !i_sys_rst && !i_fifo_empty && (w_used < DEPTH);
    end

    assign o_tvalid  = (w_occ != 2'd0);
    assign o_tdata   = w_head;
    assign o_tlast   = o_tvalid && (r_wcnt == LAST_IDX);
    assign o_pkt_cnt = r_pkt_cnt;

    // Read-latency tracker: the word requested last cycle arrives now.
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= o_fifo_rden;
        end
    end

    // Word-in-packet and completed-packet counters, advanced per transfer.
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            r_wcnt    <= 16'd0;
            r_pkt_cnt <= '0;
        end else if (w_pop) begin
            if (o_tlast) begin
                r_wcnt    <= 16'd0;
                r_pkt_cnt <= r_pkt_cnt + 1'b1;
            end else begin
                r_wcnt <= r_wcnt + 16'd1;
            end
        end
    end

endmodule
